// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller
//   Main control FSM for the multi-cycle MIPS datapath. Every instruction
//   is sequenced through fetch, decode, execute, memory and write-back.
//   The FSM drives the datapath muxes, the memory strobes and the
//   register-file write, plus the 2-bit ALU_op consumed by the ALU control
//   decoder. It also counts retired instructions and flags unsupported
//   opcodes.
//
//   Optional feature macro: MIPS_CTRL_JAL_EN
//     defined   -> opcode 000011 (jal) is decoded to the JAL state (13)
//     undefined -> jal is treated as an illegal opcode and code 13 is unreachable
//
//   Ports
//     clk, rst_n     clock, async active-low reset
//     opcode[5:0]    IR[31:26]; sampled only in DECODE and MEM_ADDR
//     zero           ALU zero flag; used only in BRANCH
//     jr             jr flag from the ALU control decoder; used only in R_EXEC
//     pc_load, PC_src, IorD, mem_read, mem_write, IR_write,
//     ALU_src_A, ALU_src_B, ALU_op, reg_dst, mem_to_reg, reg_write
//                    datapath controls
//     illegal_op     one-cycle pulse on an unsupported opcode (in DECODE)
//     state[3:0]     current state code (debug)
//     instr_count    retired-instruction counter, wraps modulo 2^CNT_W
module mips_multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             jr,
    output logic             pc_load,
    output logic [1:0]       PC_src,
    output logic             IorD,
    output logic             mem_read,
    output logic             mem_write,
    output logic             IR_write,
    output logic             ALU_src_A,
    output logic [1:0]       ALU_src_B,
    output logic [1:0]       ALU_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef MIPS_CTRL_JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_SLTI_EXEC = 4'd11,
`ifdef MIPS_CTRL_JAL_EN
        S_IMM_WB    = 4'd12,
        S_JAL       = 4'd13
`else
        S_IMM_WB    = 4'd12
`endif
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   retire;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_load    = 1'b0;
        PC_src     = 2'b00;
        IorD       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        IR_write   = 1'b0;
        ALU_src_A  = 1'b0;
        ALU_src_B  = 2'b00;
        ALU_op     = 2'b00;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                IR_write  = 1'b1;
                ALU_src_B = 2'b01;
                pc_load   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // PC + (sext(imm)<<2) is computed here so that ALUOut holds the branch target.
                ALU_src_B = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_SLTI:      state_d = S_SLTI_EXEC;
`ifdef MIPS_CTRL_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALU_src_A = 1'b1;
                ALU_src_B = 2'b10;
                state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                IorD     = 1'b1;
                state_d  = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                IorD      = 1'b1;
            end
            S_R_EXEC: begin
                ALU_src_A = 1'b1;
                ALU_op    = 2'b10;
                // jr is resolved here: the PC is loaded straight from register A, and there is no write-back.
                if (jr) begin
                    pc_load = 1'b1;
                    PC_src  = 2'b11;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_BRANCH: begin
                ALU_src_A = 1'b1;
                ALU_op    = 2'b01;
                PC_src    = 2'b01;
                pc_load   = zero;
            end
            S_JUMP: begin
                PC_src  = 2'b10;
                pc_load = 1'b1;
            end
            S_ADDI_EXEC: begin
                ALU_src_A = 1'b1;
                ALU_src_B = 2'b10;
                state_d   = S_IMM_WB;
            end
            S_SLTI_EXEC: begin
                ALU_src_A = 1'b1;
                ALU_src_B = 2'b10;
                ALU_op    = 2'b11;
                state_d   = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write = 1'b1;
            end
`ifdef MIPS_CTRL_JAL_EN
            S_JAL: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                PC_src     = 2'b10;
                pc_load    = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // An instruction retires on any return to FETCH, except for the illegal-opcode bail-out.
    assign retire = (state_q != S_FETCH) && (state_d == S_FETCH) && !illegal_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instr_count <= '0;
        else if (retire) instr_count <= instr_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       zero = 1'b0;
    logic       jr = 1'b0;
    logic       pc_load, IorD, mem_read, mem_write, IR_write, ALU_src_A, reg_write, illegal_op;
    logic [1:0] PC_src, ALU_src_B, ALU_op, reg_dst, mem_to_reg;
    logic [3:0] state;
    logic [3:0] instr_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .jr(jr),
        .pc_load(pc_load), .PC_src(PC_src), .IorD(IorD), .mem_read(mem_read),
        .mem_write(mem_write), .IR_write(IR_write), .ALU_src_A(ALU_src_A),
        .ALU_src_B(ALU_src_B), .ALU_op(ALU_op), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal_op(illegal_op),
        .state(state), .instr_count(instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_state", 32'(state), 0);
        chk("rst_cnt", 32'(instr_count), 0);
        chk("rst_illegal", 32'(illegal_op), 0);
        chk("rst_mem_read", 32'(mem_read), 1);
        chk("rst_pc_load", 32'(pc_load), 1);
        chk("rst_reg_write", 32'(reg_write), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw: 0,1,2,3,4,0
        opcode = 6'b100011;
        chk("lw_f_state", 32'(state), 0);
        chk("lw_f_irw", 32'(IR_write), 1);
        chk("lw_f_srcb", 32'(ALU_src_B), 1);
        cyc(); chk("lw_d_state", 32'(state), 1); chk("lw_d_srcb", 32'(ALU_src_B), 3);
        cyc(); chk("lw_a_state", 32'(state), 2); chk("lw_a_srca", 32'(ALU_src_A), 1);
        chk("lw_a_srcb", 32'(ALU_src_B), 2);
        cyc(); chk("lw_r_state", 32'(state), 3); chk("lw_r_mrd", 32'(mem_read), 1);
        chk("lw_r_iord", 32'(IorD), 1);
        cyc(); chk("lw_wb_state", 32'(state), 4); chk("lw_wb_rw", 32'(reg_write), 1);
        chk("lw_wb_m2r", 32'(mem_to_reg), 1); chk("lw_wb_cnt", 32'(instr_count), 0);
        cyc(); chk("lw_end_state", 32'(state), 0); chk("lw_cnt", 32'(instr_count), 1);

        // R-type, jr=0: 4 cycles
        opcode = 6'b000000; jr = 1'b0;
        cyc(); chk("r_d_state", 32'(state), 1);
        cyc(); chk("r_x_state", 32'(state), 6); chk("r_x_aluop", 32'(ALU_op), 2);
        chk("r_x_pcl", 32'(pc_load), 0);
        cyc(); chk("r_wb_state", 32'(state), 7); chk("r_wb_dst", 32'(reg_dst), 1);
        chk("r_wb_rw", 32'(reg_write), 1);
        cyc(); chk("r_end_state", 32'(state), 0); chk("r_cnt", 32'(instr_count), 2);

        // jr: 3 cycles
        jr = 1'b1;
        cyc(); chk("jr_d_state", 32'(state), 1);
        cyc(); chk("jr_x_state", 32'(state), 6); chk("jr_pcl", 32'(pc_load), 1);
        chk("jr_pcsrc", 32'(PC_src), 3);
        cyc(); chk("jr_end_state", 32'(state), 0); chk("jr_cnt", 32'(instr_count), 3);
        jr = 1'b0;

        // beq taken / not taken
        opcode = 6'b000100; zero = 1'b1;
        cyc(); chk("beq1_d_state", 32'(state), 1);
        cyc(); chk("beq1_state", 32'(state), 8); chk("beq1_pcl", 32'(pc_load), 1);
        chk("beq1_pcsrc", 32'(PC_src), 1); chk("beq1_aluop", 32'(ALU_op), 1);
        cyc(); chk("beq1_end", 32'(state), 0); chk("beq1_cnt", 32'(instr_count), 4);
        zero = 1'b0;
        cyc(); chk("beq0_d_state", 32'(state), 1);
        cyc(); chk("beq0_state", 32'(state), 8); chk("beq0_pcl", 32'(pc_load), 0);
        chk("beq0_pcsrc", 32'(PC_src), 1);
        cyc(); chk("beq0_end", 32'(state), 0); chk("beq0_cnt", 32'(instr_count), 5);

        // illegal opcode
        opcode = 6'b111111;
        chk("ill_pre", 32'(illegal_op), 0);
        cyc(); chk("ill_d_state", 32'(state), 1); chk("ill_pulse", 32'(illegal_op), 1);
        cyc(); chk("ill_end", 32'(state), 0); chk("ill_low", 32'(illegal_op), 0);
        chk("ill_cnt", 32'(instr_count), 5);

        // sw: 0,1,2,5,0
        opcode = 6'b101011;
        cyc(); chk("sw_d_state", 32'(state), 1);
        cyc(); chk("sw_a_state", 32'(state), 2);
        cyc(); chk("sw_w_state", 32'(state), 5); chk("sw_mw", 32'(mem_write), 1);
        chk("sw_iord", 32'(IorD), 1);
        cyc(); chk("sw_end", 32'(state), 0); chk("sw_cnt", 32'(instr_count), 6);

        // addi, slti
        opcode = 6'b001000;
        cyc(); cyc(); chk("addi_x_state", 32'(state), 10); chk("addi_srcb", 32'(ALU_src_B), 2);
        chk("addi_aluop", 32'(ALU_op), 0);
        cyc(); chk("addi_wb_state", 32'(state), 12); chk("addi_rw", 32'(reg_write), 1);
        chk("addi_dst", 32'(reg_dst), 0);
        cyc(); chk("addi_end", 32'(state), 0); chk("addi_cnt", 32'(instr_count), 7);
        opcode = 6'b001010;
        cyc(); cyc(); chk("slti_x_state", 32'(state), 11); chk("slti_aluop", 32'(ALU_op), 3);
        cyc(); chk("slti_wb_state", 32'(state), 12);
        cyc(); chk("slti_end", 32'(state), 0); chk("slti_cnt", 32'(instr_count), 8);

        // reset during MEM_WB of lw
        opcode = 6'b100011;
        cyc(); cyc(); cyc(); cyc();
        chk("rmid_state_pre", 32'(state), 4); chk("rmid_rw_pre", 32'(reg_write), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rmid_rw", 32'(reg_write), 0); chk("rmid_state", 32'(state), 0);
        chk("rmid_cnt", 32'(instr_count), 0); chk("rmid_mw", 32'(mem_write), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 17 j instructions wrap a 4-bit counter to 1
        opcode = 6'b000010;
        for (int i = 0; i < 17; i++) begin
            cyc(); cyc();
            if (i == 0) begin
                chk("j_state", 32'(state), 9); chk("j_pcl", 32'(pc_load), 1);
                chk("j_pcsrc", 32'(PC_src), 2);
            end
            cyc();
        end
        chk("j_wrap_state", 32'(state), 0);
        chk("j_wrap_cnt", 32'(instr_count), 1);

        // jal
        opcode = 6'b000011;
`ifdef MIPS_CTRL_JAL_EN
        cyc(); chk("jal_d_state", 32'(state), 1); chk("jal_no_ill", 32'(illegal_op), 0);
        cyc(); chk("jal_state", 32'(state), 13); chk("jal_dst", 32'(reg_dst), 2);
        chk("jal_m2r", 32'(mem_to_reg), 2); chk("jal_rw", 32'(reg_write), 1);
        chk("jal_pcl", 32'(pc_load), 1); chk("jal_pcsrc", 32'(PC_src), 2);
        cyc(); chk("jal_end", 32'(state), 0); chk("jal_cnt", 32'(instr_count), 2);
`else
        cyc(); chk("jal_d_state", 32'(state), 1); chk("jal_ill", 32'(illegal_op), 1);
        cyc(); chk("jal_end", 32'(state), 0); chk("jal_cnt", 32'(instr_count), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
